rgmii_rx_ctrl: RTL and testbench
================================

Name: rgmii_rx_ctrl

Overview:
- Sequences the RGMII receive datapath.
- Consumes per-pin DDR samples (two samples per pin per clock) from the input DDR capture cells for RXD[3:0] and RX_CTL, and reassembles bytes.
- Strips preamble/SFD, delimits frames and flags errors.
- Emits a byte stream with last/abort markers to the Ethernet RX MAC pipeline.
- Sits between the pin-level DDR primitives and the CRC/address-filter stages.

Parameters:
- MAX_FRAME_LEN, 1536: maximum data bytes after SFD; the next byte aborts the frame.
- LGMAXLEN, 11: width of the frame byte counter; must satisfy 2^LGMAXLEN > MAX_FRAME_LEN.
- MIN_PREAMBLE, 1: minimum 0x55 bytes required before SFD (0..7).

Ports:
- i_clk, input, 1: RX clock (RGMII RXC domain). One clock; all logic on rising edge.
- i_reset, input, 1: reset, synchronous, active-high.
- i_rxd_lo, input, 4: RXD sampled on first (rising) edge = byte bits [3:0].
- i_rxd_hi, input, 4: RXD sampled on second (falling) edge = byte bits [7:4].
- i_rxctl, input, 2: [0] = RX_DV (first edge); [1] = RX_DV^RX_ER (second edge).
- o_valid, output, 1: o_data is valid this cycle.
- o_data, output, 8: received data byte.
- o_last, output, 1: qualifies o_valid; final byte of a good frame.
- o_abort, output, 1: one-cycle pulse (o_valid=0); current frame is bad and must be discarded.
- o_link_up, output, 1: in-band link status.
- o_speed, output, 2: in-band speed, 00=10M, 01=100M, 10=1G.
- o_full_duplex, output, 1: in-band duplex.

Behaviour:
- Input stage: register byte = {i_rxd_hi, i_rxd_lo}, dv = i_rxctl[0], er = i_rxctl[0]^i_rxctl[1].
- FSM runs on the registered values.
- States:
  - IDLE: dv&!er&byte==0x55 -> PRE, pcnt=1. Other dv=1 -> DROP. dv=0 -> stay.
  - PRE:
    - dv&!er&0x55 -> stay, pcnt saturates at 7.
    - dv&!er&0xD5&pcnt>=MIN_PREAMBLE -> DATA, bcnt=0, hold empty.
    - !dv -> IDLE.
    - Anything else -> DROP.
  - DATA:
    - dv&!er: byte goes into the hold register. If hold was full, the previous byte is emitted (o_valid=1, o_last=0). bcnt++.
    - dv&!er when bcnt==MAX_FRAME_LEN: o_abort -> DROP.
    - dv&er: o_abort -> DROP.
    - !dv with hold full: emit held byte with o_last=1 -> IDLE.
    - !dv with hold empty (zero-length frame): o_abort -> IDLE.
  - DROP: wait for !dv -> IDLE. No output.
- Latency: a byte presented at input cycle t appears on o_data at t+3, provided byte t+1 exists or dv falls at t+1.
- One byte per clock max; no backpressure.
- Framing invariant: every entry into DATA ends with exactly one o_last or one o_abort, never both. o_last and o_abort are never asserted in the same cycle.
- Between entry into DATA and its terminator, o_valid bytes are exactly the post-SFD bytes, in order.
- dv=0&er=1 (carrier extend/false carrier): treated as dv=0 for framing.
- Reset:
  - o_valid, o_last, o_abort, o_data = 0.
  - o_link_up = 0, o_speed = 00, o_full_duplex = 0.
  - State IDLE; hold and counters cleared.
  - Mid-frame reset: no o_last/o_abort is emitted for the interrupted frame. Remaining bytes fall into DROP until dv=0.
- o_data is don't-care when o_valid=0, but is held at its last value.

Optional Feature:
- Macro: RGMII_INBAND_STATUS_EN.
- With the macro:
  - In IDLE with dv=0&er=0 and i_rxd_lo==i_rxd_hi, decode the nibble: bit0 = link, bits2:1 = speed, bit3 = duplex.
  - Outputs update only after two consecutive identical nibbles.
  - Reserved speed 11 is ignored (outputs unchanged).
- Without the macro: o_link_up, o_speed and o_full_duplex are constant 0; ports remain present.

Decomposition:
- Package rgmii_pkg:
  - FSM state enum (IDLE, PRE, DATA, DROP).
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
  - Speed encodings SPD_10/SPD_100/SPD_1G.
- Sub-module rgmii_rx_inband: in-band status decoder and debounce. Instantiated only under RGMII_INBAND_STATUS_EN.

Test Plan:
- Seven 0x55, then 0xD5, then data 0x01..0x40 (64 bytes), then dv=0: 64 o_valid in order; o_last only with 0x40; first byte 3 cycles after input; no o_abort.
- Same frame with er=1 on data byte 10: 9 bytes emitted, then one o_abort, no o_last; bytes after the error are ignored until dv=0.
- Preamble/SFD then dv drops immediately: a single o_abort, no o_valid. With MIN_PREAMBLE=2, a single 0x55 then SFD: no output, no abort.
- MAX_FRAME_LEN+1 data bytes: MAX_FRAME_LEN-1 bytes emitted, then o_abort, no o_last; next back-to-back frame (1-cycle IFG) received correctly.
- Reset asserted mid-DATA: outputs 0 next cycle, no terminator; frame tail dropped; following frame received intact.
- RGMII_INBAND_STATUS_EN: idle nibbles 0xD,0xD: o_link_up=1, o_speed=10, o_full_duplex=1. A single 0x0 nibble leaves the outputs unchanged; with the macro off, the outputs stay 0.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive path: FSM states, framing bytes
// and in-band speed encodings.
package rgmii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [1:0] SPD_10  = 2'b00;
    localparam logic [1:0] SPD_100 = 2'b01;
    localparam logic [1:0] SPD_1G  = 2'b10;

    // Encoding 2'b11 is reserved and must not reach the status outputs.
    function automatic logic speed_valid(input logic [1:0] spd);
        return (spd == SPD_10) || (spd == SPD_100) || (spd == SPD_1G);
    endfunction

endpackage

// File: rtl/rgmii_rx_inband.sv
// In-band link/speed/duplex decoder with two-sample debounce. Only built when
// RGMII_INBAND_STATUS_EN is defined.
`ifdef RGMII_INBAND_STATUS_EN
module rgmii_rx_inband
    import rgmii_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sample,
    input  logic [3:0] nibble,
    output logic       link_up,
    output logic [1:0] speed,
    output logic       full_duplex
);

    logic [3:0] prev_nibble;
    logic       prev_ok;

    // A non-qualifying cycle breaks the run, so two matches must be back to back.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_nibble <= 4'h0;
            prev_ok     <= 1'b0;
            link_up     <= 1'b0;
            speed       <= SPD_10;
            full_duplex <= 1'b0;
        end else if (sample) begin
            prev_nibble <= nibble;
            prev_ok     <= 1'b1;
            if (prev_ok && (prev_nibble == nibble) && speed_valid(nibble[2:1])) begin
                link_up     <= nibble[0];
                speed       <= nibble[2:1];
                full_duplex <= nibble[3];
            end
        end else begin
            prev_ok <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive sequencer: rebuilds bytes from DDR samples, strips preamble/SFD and
// delimits frames. Define RGMII_INBAND_STATUS_EN to decode in-band link status.
module rgmii_rx_ctrl
    import rgmii_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1536,
    parameter int LGMAXLEN      = 11,
    parameter int MIN_PREAMBLE  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_rxd_lo,
    input  logic [3:0] i_rxd_hi,
    input  logic [1:0] i_rxctl,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_abort,
    output logic       o_link_up,
    output logic [1:0] o_speed,
    output logic       o_full_duplex
);

    // Output stream: o_valid marks o_data for exactly one cycle and there is no
    // ready; the consumer must take every valid byte. o_last rides with the final
    // valid byte of a good frame, o_abort is a standalone pulse with o_valid low.

    logic [7:0] r_byte;
    logic       r_dv;
    logic       r_er;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_byte <= 8'h00;
            r_dv   <= 1'b0;
            r_er   <= 1'b0;
        end else begin
            r_byte <= {i_rxd_hi, i_rxd_lo};
            r_dv   <= i_rxctl[0];
            r_er   <= i_rxctl[0] ^ i_rxctl[1];
        end
    end

    rx_state_t           state, state_nx;
    logic [2:0]          pcnt, pcnt_nx;
    logic [LGMAXLEN-1:0] bcnt, bcnt_nx;
    logic [7:0]          hold, hold_nx;
    logic                hold_full, hold_full_nx;
    logic                emit, emit_last, emit_abort;
    logic                good;

    // er is only meaningful with dv; dv=0 with er=1 is carrier extend and frames like idle.
    assign good = r_dv && !r_er;

    always_comb begin
        state_nx     = state;
        pcnt_nx      = pcnt;
        bcnt_nx      = bcnt;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        emit         = 1'b0;
        emit_last    = 1'b0;
        emit_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (good && (r_byte == PREAMBLE_BYTE)) begin
                    state_nx = PRE;
                    pcnt_nx  = 3'd1;
                end else if (r_dv) begin
                    state_nx = DROP;
                end
            end
            PRE: begin
                if (!r_dv) begin
                    state_nx = IDLE;
                end else if (good && (r_byte == PREAMBLE_BYTE)) begin
                    if (pcnt != 3'd7) begin
                        pcnt_nx = pcnt + 3'd1;
                    end
                end else if (good && (r_byte == SFD_BYTE) && (pcnt >= 3'(MIN_PREAMBLE))) begin
                    state_nx     = DATA;
                    bcnt_nx      = '0;
                    hold_full_nx = 1'b0;
                end else begin
                    state_nx = DROP;
                end
            end
            DATA: begin
                // One byte is always held back so the end of frame can tag it with o_last.
                if (!r_dv) begin
                    state_nx     = IDLE;
                    hold_full_nx = 1'b0;
                    if (hold_full) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                    end else begin
                        emit_abort = 1'b1;
                    end
                end else if (r_er || (bcnt == LGMAXLEN'(MAX_FRAME_LEN))) begin
                    state_nx     = DROP;
                    hold_full_nx = 1'b0;
                    emit_abort   = 1'b1;
                end else begin
                    emit         = hold_full;
                    hold_nx      = r_byte;
                    hold_full_nx = 1'b1;
                    bcnt_nx      = bcnt + 1'b1;
                end
            end
            DROP: begin
                if (!r_dv) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            pcnt      <= 3'd0;
            bcnt      <= '0;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_abort   <= 1'b0;
            o_data    <= 8'h00;
        end else begin
            state     <= state_nx;
            pcnt      <= pcnt_nx;
            bcnt      <= bcnt_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
            o_valid   <= emit;
            o_last    <= emit_last;
            o_abort   <= emit_abort;
            if (emit) begin
                o_data <= hold;
            end
        end
    end

`ifdef RGMII_INBAND_STATUS_EN
    logic inband_sample;

    // Status nibbles are repeated on both edges during normal inter-frame idle.
    assign inband_sample = (state == IDLE) && !r_dv && !r_er && (r_byte[3:0] == r_byte[7:4]);

    rgmii_rx_inband u_inband (
        .clk         (i_clk),
        .reset       (i_reset),
        .sample      (inband_sample),
        .nibble      (r_byte[3:0]),
        .link_up     (o_link_up),
        .speed       (o_speed),
        .full_duplex (o_full_duplex)
    );
`else
    assign o_link_up     = 1'b0;
    assign o_speed       = SPD_10;
    assign o_full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// Directed bench for rgmii_rx_ctrl: table of frames plus hand sequences for reset
// mid-frame and in-band status.
module tb_rgmii_rx_ctrl;

`ifdef RGMII_INBAND_STATUS_EN
    localparam bit INBAND = 1'b1;
`else
    localparam bit INBAND = 1'b0;
`endif

    logic       clk;
    logic       i_reset;
    logic [3:0] i_rxd_lo;
    logic [3:0] i_rxd_hi;
    logic [1:0] i_rxctl;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_abort;
    logic       o_link_up;
    logic [1:0] o_speed;
    logic       o_full_duplex;

    rgmii_rx_ctrl #(
        .MAX_FRAME_LEN (1536),
        .LGMAXLEN      (11),
        .MIN_PREAMBLE  (2)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_rxd_lo      (i_rxd_lo),
        .i_rxd_hi      (i_rxd_hi),
        .i_rxctl       (i_rxctl),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_abort       (o_abort),
        .o_link_up     (o_link_up),
        .o_speed       (o_speed),
        .o_full_duplex (o_full_duplex)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // expected events: [9:8] kind (0 data, 1 last data, 2 abort), [7:0] byte
    logic [9:0] exp_q[$];
    bit  seen_first;
    int  first_valid_cyc;
    int  data_start_cyc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // scoreboard on the falling edge
    always @(negedge clk) begin
        logic [9:0] e;
        logic [1:0] kind;
        if (o_valid || o_abort || o_last) begin
            chk("framing_flags_exclusive",
                {29'b0, o_valid & o_abort, o_last & o_abort, o_last & !o_valid}, 32'd0);
            kind = o_abort ? 2'd2 : (o_last ? 2'd1 : 2'd0);
            if (o_valid && !seen_first) begin
                seen_first      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: kind %0d data 0x%0h with nothing expected (cycle %0d)",
                         kind, o_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rx_event", {22'b0, kind, (o_abort ? 8'h00 : o_data)}, {22'b0, e});
            end
        end
    end

    // driver tasks
    task automatic drive(input logic [7:0] b, input logic dv, input logic er);
        @(posedge clk);
        #1;
        i_rxd_lo = b[3:0];
        i_rxd_hi = b[7:4];
        i_rxctl  = {dv ^ er, dv};
    endtask

    task automatic send_frame(input int n_pre, input bit sfd, input int n_data,
                              input int err_idx, input int ifg, input logic [7:0] base);
        for (int i = 0; i < n_pre; i++) drive(8'h55, 1'b1, 1'b0);
        if (sfd) drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < n_data; i++) begin
            if (i == 0) seen_first = 1'b0;
            drive(8'(base + i), 1'b1, (i == err_idx));
            if (i == 0) data_start_cyc = cyc;
        end
        for (int i = 0; i < ifg; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_bytes(input int n, input bit with_last, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            exp_q.push_back({((with_last && (i == n - 1)) ? 2'd1 : 2'd0), 8'(base + i)});
    endtask

    typedef struct {
        int         n_pre;
        bit         sfd;
        int         n_data;
        int         err_idx;
        int         ifg;
        logic [7:0] base;
        int         exp_valid;
        bit         exp_last;
        bit         exp_abort;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // n_pre sfd n_data err ifg base | valid last abort  (DUT built with MIN_PREAMBLE=2)
        vecs[0] = '{7, 1'b1,   64, -1, 6, 8'h01,   64, 1'b1, 1'b0}; // nominal frame
        vecs[1] = '{7, 1'b1,   64, 10, 6, 8'h01,    9, 1'b0, 1'b1}; // er on index 10
        vecs[2] = '{7, 1'b1,    0, -1, 6, 8'h00,    0, 1'b0, 1'b1}; // zero-length frame
        vecs[3] = '{1, 1'b1,    8, -1, 6, 8'h20,    0, 1'b0, 1'b0}; // short preamble
        vecs[4] = '{2, 1'b1,    5, -1, 6, 8'h30,    5, 1'b1, 1'b0}; // minimum preamble
        vecs[5] = '{0, 1'b1,    4, -1, 6, 8'h40,    0, 1'b0, 1'b0}; // SFD without preamble
        vecs[6] = '{7, 1'b1,    1, -1, 6, 8'h77,    1, 1'b1, 1'b0}; // single byte
        vecs[7] = '{7, 1'b1, 1537, -1, 1, 8'h00, 1535, 1'b0, 1'b1}; // over-length, 1-cycle IFG
        vecs[8] = '{7, 1'b1,    3, -1, 6, 8'hC0,    3, 1'b1, 1'b0}; // back-to-back follower

        i_reset  = 1'b1;
        i_rxd_lo = 4'h0;
        i_rxd_hi = 4'h0;
        i_rxctl  = 2'b00;
        seen_first = 1'b1;
        first_valid_cyc = 0;
        data_start_cyc = 0;
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_valid", {31'b0, o_valid}, 32'd0);
        chk("reset_last", {31'b0, o_last}, 32'd0);
        chk("reset_abort", {31'b0, o_abort}, 32'd0);
        chk("reset_data", {24'b0, o_data}, 32'd0);
        chk("reset_link_up", {31'b0, o_link_up}, 32'd0);
        chk("reset_speed", {30'b0, o_speed}, 32'd0);
        chk("reset_duplex", {31'b0, o_full_duplex}, 32'd0);
        drive(8'h00, 1'b0, 1'b0);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);

        for (int v = 0; v < 9; v++) begin
            expect_bytes(vecs[v].exp_valid, vecs[v].exp_last, vecs[v].base);
            if (vecs[v].exp_abort) exp_q.push_back({2'd2, 8'h00});
            send_frame(vecs[v].n_pre, vecs[v].sfd, vecs[v].n_data, vecs[v].err_idx,
                       vecs[v].ifg, vecs[v].base);
            if (vecs[v].exp_valid > 0 && vecs[v].ifg >= 4)
                chk($sformatf("latency_vec%0d", v),
                    seen_first ? (first_valid_cyc - data_start_cyc) : 32'hFFFF_FFFF, 32'd3);
        end

        // reset in the middle of DATA: A0..A2 already out, A3.. dropped, no terminator
        expect_bytes(3, 1'b0, 8'hA0);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(8'(8'hA0 + i), 1'b1, 1'b0);
        drive(8'hA5, 1'b1, 1'b0);
        i_reset = 1'b1;
        drive(8'hA6, 1'b1, 1'b0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("midreset_valid", {31'b0, o_valid}, 32'd0);
        chk("midreset_last", {31'b0, o_last}, 32'd0);
        chk("midreset_abort", {31'b0, o_abort}, 32'd0);
        chk("midreset_data", {24'b0, o_data}, 32'd0);
        for (int i = 7; i < 10; i++) drive(8'(8'hA0 + i), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(8'h00, 1'b0, 1'b0);
        chk("midreset_queue_empty", exp_q.size(), 32'd0);
        expect_bytes(4, 1'b1, 8'hB0);
        send_frame(7, 1'b1, 4, -1, 6, 8'hB0);
        chk("post_reset_latency", seen_first ? (first_valid_cyc - data_start_cyc) : 32'hFFFF_FFFF, 32'd3);

        // in-band status: two 0xD idle nibbles, then a lone 0x0 nibble
        drive(8'hDD, 1'b0, 1'b0);
        drive(8'hDD, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'h12, 1'b0, 1'b0);
        @(negedge clk);
        chk("inband_link_up", {31'b0, o_link_up}, {31'b0, INBAND});
        chk("inband_speed", {30'b0, o_speed}, {30'b0, INBAND, 1'b0});
        chk("inband_duplex", {31'b0, o_full_duplex}, {31'b0, INBAND});
        drive(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'h12, 1'b0, 1'b0);
        @(negedge clk);
        chk("inband_hold_link_up", {31'b0, o_link_up}, {31'b0, INBAND});
        chk("inband_hold_speed", {30'b0, o_speed}, {30'b0, INBAND, 1'b0});
        chk("inband_hold_duplex", {31'b0, o_full_duplex}, {31'b0, INBAND});

        for (int i = 0; i < 8; i++) drive(8'h00, 1'b0, 1'b0);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
